// File: rtl/noc_retry_replayer.sv
// Transmit-side replay buffer for a NoC ring link: holds sent-but-unacked flits
// and rewinds to the oldest one when the far-end parity healer requests a retry.
module noc_retry_replayer #(
   parameter int DATA_W    = 64,
   parameter int DEPTH     = 8,
   parameter int PTR_W     = $clog2(DEPTH),
   parameter int MAX_RETRY = 3
) (
   input  logic              clk_1p6ghz,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              link_valid,
   input  logic              link_ready,
   output logic [DATA_W-1:0] link_data,
   output logic              link_parity,
   output logic [PTR_W-1:0]  link_seq,
   input  logic              ack,
   input  logic              retry_request,
   output logic              replay_active,
   output logic              retry_fail,
   output logic [PTR_W:0]    occupancy
);

   localparam int PW    = PTR_W + 1;
   localparam int CNT_W = $clog2(MAX_RETRY + 2);

   typedef enum logic [1:0] {NORMAL, REPLAY, HALT} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       head_q, head_d;
   logic [PW-1:0]       send_q, send_d;
   logic [PW-1:0]       hwm_q, hwm_d;
   logic [PW-1:0]       tail_q, tail_d;
   logic [PW-1:0]       end_q, end_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                retry_prev_q;
   logic                pending_q, pending_d;
   logic                in_ready_q, in_ready_d;
   logic                link_valid_q, link_valid_d;
   logic [DATA_W-1:0]   link_data_q, link_data_d;
   logic                link_parity_q, link_parity_d;
   logic [PTR_W-1:0]    link_seq_q, link_seq_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept;
   logic                ack_eff;
   logic                counted;
   logic                overflow;
   logic                halting;
   logic                out_free;
   logic                rewind_req;
   logic                rewind_now;
   logic                load;
   logic [PW-1:0]       send_a;
   logic [DATA_W-1:0]   data_sel;

   always_comb begin
      accept     = in_valid && in_ready_q;
      tail_d     = tail_q + PW'(accept);

      // Ack is applied before any retry in the same cycle, so a simultaneous
      // retry sees the advanced head and a cleared counter.
      ack_eff    = ack && (hwm_q != head_q);
      head_d     = head_q + PW'(ack_eff);
      cnt_d      = ack_eff ? '0 : cnt_q;

      counted    = retry_request && !retry_prev_q && (hwm_q != head_d) && (state_q != HALT);
      cnt_d      = cnt_d + CNT_W'(counted);
      overflow   = counted && (cnt_d > CNT_W'(MAX_RETRY));
      halting    = overflow || (state_q == HALT);

      out_free   = !link_valid_q || link_ready;
      rewind_req = !overflow && (counted || pending_q);
      rewind_now = rewind_req && out_free;
      pending_d  = rewind_req && !out_free;

      send_a = send_q;
      if (rewind_now) begin
         send_a = head_d;
      end else if (ack_eff && (send_q == head_q)) begin
         send_a = head_d;
      end

      load   = out_free && !halting && ((send_a != tail_q) || accept);
      send_d = send_a + PW'(load);
      hwm_d  = hwm_q;
      if (load && (send_a == hwm_q)) begin
         hwm_d = hwm_q + PW'(1);
      end

      // Bypass lets a flit accepted this cycle go straight to the output register.
      data_sel      = (send_a == tail_q) ? in_data : mem_q[send_a[PTR_W-1:0]];
      link_valid_d  = link_valid_q && !link_ready;
      link_data_d   = link_data_q;
      link_parity_d = link_parity_q;
      link_seq_d    = link_seq_q;
      if (load) begin
         link_valid_d  = 1'b1;
         link_data_d   = data_sel;
         link_parity_d = ^data_sel;
         link_seq_d    = send_a[PTR_W-1:0];
      end

      state_d = state_q;
      end_d   = end_q;
      if (overflow) begin
         state_d = HALT;
      end else if (counted) begin
         state_d = REPLAY;
         end_d   = hwm_q;
      end else if ((state_q == REPLAY) && !pending_d &&
                   ((send_a == end_q) || (send_d == end_q))) begin
         state_d = NORMAL;
      end

      in_ready_d = ((tail_d - head_d) < PW'(DEPTH)) && (state_d != HALT);
   end

   always_ff @(posedge clk_1p6ghz or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= NORMAL;
         head_q        <= '0;
         send_q        <= '0;
         hwm_q         <= '0;
         tail_q        <= '0;
         end_q         <= '0;
         cnt_q         <= '0;
         retry_prev_q  <= 1'b0;
         pending_q     <= 1'b0;
         in_ready_q    <= 1'b0;
         link_valid_q  <= 1'b0;
         link_data_q   <= '0;
         link_parity_q <= 1'b0;
         link_seq_q    <= '0;
      end else begin
         state_q       <= state_d;
         head_q        <= head_d;
         send_q        <= send_d;
         hwm_q         <= hwm_d;
         tail_q        <= tail_d;
         end_q         <= end_d;
         cnt_q         <= cnt_d;
         retry_prev_q  <= retry_request;
         pending_q     <= pending_d;
         in_ready_q    <= in_ready_d;
         link_valid_q  <= link_valid_d;
         link_data_q   <= link_data_d;
         link_parity_q <= link_parity_d;
         link_seq_q    <= link_seq_d;
      end
   end

   // Storage needs no reset: entries are only read between head and tail.
   always_ff @(posedge clk_1p6ghz) begin
      if (accept) begin
         mem_q[tail_q[PTR_W-1:0]] <= in_data;
      end
   end

   assign in_ready      = in_ready_q;
   assign link_valid    = link_valid_q;
   assign link_data     = link_data_q;
   assign link_parity   = link_parity_q;
   assign link_seq      = link_seq_q;
   assign replay_active = (state_q == REPLAY);
   assign retry_fail    = (state_q == HALT);
   assign occupancy     = tail_q - head_q;

endmodule
